pp_issue_8: RTL and testbench
=============================

// Module: pp_issue_8
// PURPOSE
// - Producer side of the carry_save_8 partial-product interface.
// - Accepts one 32-bit A x B multiply request, splits A and B into bytes, and forms 8x8 unsigned partial products.
// - Issues the products as 8-slot beats on mult_out_1..8, with start and sew, into the carry-save accumulator.
// - After issuing, holds off new requests for a drain window so the accumulator can finish.
// PARAMETERS
// - DRAIN_CYCLES  4  idle cycles after the last beat before in_ready re-asserts (>=1)
// PORTS
// - clk          in   1   clock; single clock domain
// - reset        in   1   synchronous, active-high reset
// - in_valid     in   1   request valid
// - in_ready     out  1   request accepted when in_valid & in_ready at a rising edge
// - in_a         in   32  operand A
// - in_b         in   32  operand B
// - in_sew       in   2   00 = 4 x 8-bit lanes; 01 = 2 x 16-bit lanes; 10 = 1 x 32-bit; 11 = illegal
// - start        out  1   beat valid; drives carry_save_8 start
// - sew          out  2   latched in_sew; held constant across all beats of a request
// - pp_last      out  1   high on the final beat of a request
// - mult_out_1..8  out  16 each  partial-product slots
// - busy         out  1   high from accept until the drain window ends
// - err_sew      out  1   one-cycle pulse when a request with in_sew = 11 is accepted
// BEHAVIOUR
// - Reset values: in_ready = 1; all other outputs 0; FSM in IDLE; operand registers cleared.
// - Notation: Ai = in_a[8i+7:8i], Bj = in_b[8j+7:8j]. Each product is an unsigned 16-bit value.
// - Beat contents (slot 1..8):
//   - sew 00 (1 beat): A0B0, A1B1, A2B2, A3B3, 0, 0, 0, 0.
//   - sew 01 (1 beat): A0B0, A1B0, A0B1, A1B1, A2B2, A3B2, A2B3, A3B3.
//   - sew 10 (2 beats): beat0 = A0B0, A1B0, A2B0, A3B0, A0B1, A1B1, A2B1, A3B1; beat1 = A0B2 .. A3B2, A0B3 .. A3B3.
// - FSM IDLE -> ISSUE0 -> [ISSUE1 if sew 10] -> DRAIN -> IDLE.
// - in_ready = 1 only in IDLE. Operands and sew are latched at the accept edge.
// - All outputs are registered.
//   - beat0 is visible in the cycle after the accept edge, with start = 1.
//   - A sew 10 request shows beat1 in the next cycle.
//   - pp_last = 1 on beat0 for sew 00 and 01, and on beat1 for sew 10.
// - No downstream back-pressure: beats are issued on consecutive cycles unconditionally.
// - When start = 0, mult_out_1..8 are 0 and pp_last is 0. sew is retained.
// - DRAIN: down-counter loaded with DRAIN_CYCLES on the cycle after the last beat.
//   - busy = 1, in_ready = 0.
//   - Returns to IDLE when the counter reaches 0.
//   - The next accept is possible DRAIN_CYCLES cycles after the last beat.
// - sew 11: the request is accepted and err_sew pulses the cycle after accept. No beats are issued and there is no DRAIN; FSM returns to IDLE immediately.
// - Reset mid-request: the request is abandoned. Next cycle shows reset values; no partial beat is completed after reset.
// - in_a, in_b and in_sew are ignored whenever in_ready = 0.
// CONFIGURATION
// - MULT_PIPE_EN defined:
//   - Adds a register stage between the byte multipliers and the mult_out registers.
//   - Every beat, pp_last and start appear 1 cycle later (first beat 2 cycles after accept).
//   - The DRAIN start shifts by the same cycle. Beat contents and ordering are unchanged.
// - MULT_PIPE_EN undefined: the timing above applies; the multipliers are combinational into the output registers.
// TESTING
// - sew 10, A = B = 32'hFFFFFFFF:
//   - beat0 and beat1 all slots = 16'hFE01; pp_last on beat1 only.
//   - Accumulated {product_2, product_1} = 64'hFFFFFFFE_00000001.
// - sew 00, A = 32'h04030201, B = 32'h08070605: slots = 0005, 000C, 0015, 0020, 0, 0, 0, 0; single beat with pp_last = 1.
// - sew 01, same operands: slots = 0005, 000A, 0006, 000C, 0015, 001C, 0018, 0020.
// - Back-to-back, in_valid held high, DRAIN_CYCLES = 4:
//   - in_ready low for exactly 4 cycles after the last beat.
//   - Second request accepted on the following edge.
// - in_sew = 11: err_sew pulses 1 cycle, start never asserts, in_ready = 1 the next cycle.
// - reset asserted during beat0 of a sew 10 request: next cycle start = 0, all slots 0, in_ready = 1; no beat1 ever issued.

Source files
------------

// File: rtl/pp_issue_8.sv
// ============================================================================
// Module      : pp_issue_8
// Description : Producer side of the carry_save_8 partial-product interface.
//               Splits a 32-bit A x B request into 8x8 unsigned products and
//               issues them as 8-slot beats, then holds off for a drain window.
//               Optional macro MULT_PIPE_EN adds a multiplier register stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pp_issue_8 #(
    parameter int DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [1:0]  in_sew,
    output logic        start,
    output logic [1:0]  sew,
    output logic        pp_last,
    output logic [15:0] mult_out_1,
    output logic [15:0] mult_out_2,
    output logic [15:0] mult_out_3,
    output logic [15:0] mult_out_4,
    output logic [15:0] mult_out_5,
    output logic [15:0] mult_out_6,
    output logic [15:0] mult_out_7,
    output logic [15:0] mult_out_8,
    output logic        busy,
    output logic        err_sew
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE0 = 2'd1;
    localparam logic [1:0] ST_ISSUE1 = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    localparam logic [1:0] SEW_32  = 2'b10;
    localparam logic [1:0] SEW_BAD = 2'b11;

    // The FSM runs one cycle ahead of the outputs when the extra stage is present,
    // so the drain window is stretched by one to keep it aligned to the last beat.
`ifdef MULT_PIPE_EN
    localparam int DRAIN_LOAD = DRAIN_CYCLES + 1;
`else
    localparam int DRAIN_LOAD = DRAIN_CYCLES;
`endif
    localparam int              CNT_W      = $clog2(DRAIN_LOAD + 1);
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_LOAD);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    function automatic logic [15:0] pp(input logic [31:0] a, input logic [31:0] b,
                                       input int i, input int j);
        return {8'd0, a[8*i +: 8]} * {8'd0, b[8*j +: 8]};
    endfunction

    // Slot 1 occupies bits [15:0], slot 8 bits [127:112].
    function automatic logic [127:0] beat(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] s, input logic second);
        logic [127:0] r;
        int           j0;
        r  = '0;
        j0 = second ? 2 : 0;
        case (s)
            2'b00: r = {64'd0, pp(a, b, 3, 3), pp(a, b, 2, 2), pp(a, b, 1, 1), pp(a, b, 0, 0)};
            2'b01: r = {pp(a, b, 3, 3), pp(a, b, 2, 3), pp(a, b, 3, 2), pp(a, b, 2, 2),
                        pp(a, b, 1, 1), pp(a, b, 0, 1), pp(a, b, 1, 0), pp(a, b, 0, 0)};
            2'b10: begin
                for (int k = 0; k < 4; k++) begin
                    r[16*k +: 16]     = pp(a, b, k, j0);
                    r[16*(k+4) +: 16] = pp(a, b, k, j0 + 1);
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [1:0]       sew_q, sew_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             err_sew_q, err_sew_d;
    logic             start_q, start_d;
    logic             pp_last_q, pp_last_d;
    logic [127:0]     slots_q, slots_d;

    logic             beat_vld;
    logic             beat_last;
    logic [127:0]     beat_slots;
    logic             accept;

`ifdef MULT_PIPE_EN
    logic             pv_q, pv_d, pl_q, pl_d;
    logic [127:0]     ps_q, ps_d;
`endif

    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        sew_d      = sew_q;
        in_ready_d = in_ready_q;
        busy_d     = busy_q;
        err_sew_d  = 1'b0;
        beat_vld   = 1'b0;
        beat_last  = 1'b0;
        beat_slots = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d   = in_a;
                    b_d   = in_b;
                    sew_d = in_sew;
                    if (in_sew == SEW_BAD) begin
                        err_sew_d = 1'b1;
                    end else begin
                        // Beat0 comes straight from the inputs so it is visible next cycle.
                        beat_vld   = 1'b1;
                        beat_last  = (in_sew != SEW_32);
                        beat_slots = beat(in_a, in_b, in_sew, 1'b0);
                        state_d    = ST_ISSUE0;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
                    end
                end
            end
            ST_ISSUE0: begin
                if (sew_q == SEW_32) begin
                    beat_vld   = 1'b1;
                    beat_last  = 1'b1;
                    beat_slots = beat(a_q, b_q, SEW_32, 1'b1);
                    state_d    = ST_ISSUE1;
                end else begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_INIT;
                end
            end
            ST_ISSUE1: begin
                state_d = ST_DRAIN;
                cnt_d   = DRAIN_INIT;
            end
            default: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d    = ST_IDLE;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end
        endcase
    end

`ifdef MULT_PIPE_EN
    always_comb begin
        pv_d      = beat_vld;
        pl_d      = beat_last;
        ps_d      = beat_slots;
        start_d   = pv_q;
        pp_last_d = pl_q;
        slots_d   = ps_q;
    end
`else
    always_comb begin
        start_d   = beat_vld;
        pp_last_d = beat_last;
        slots_d   = beat_slots;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sew_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            err_sew_q  <= 1'b0;
            start_q    <= 1'b0;
            pp_last_q  <= 1'b0;
            slots_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sew_q      <= sew_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            err_sew_q  <= err_sew_d;
            start_q    <= start_d;
            pp_last_q  <= pp_last_d;
            slots_q    <= slots_d;
        end
    end

`ifdef MULT_PIPE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pv_q <= 1'b0;
            pl_q <= 1'b0;
            ps_q <= '0;
        end else begin
            pv_q <= pv_d;
            pl_q <= pl_d;
            ps_q <= ps_d;
        end
    end
`endif

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign err_sew    = err_sew_q;
    assign start      = start_q;
    assign pp_last    = pp_last_q;
    assign sew        = sew_q;
    assign mult_out_1 = slots_q[15:0];
    assign mult_out_2 = slots_q[31:16];
    assign mult_out_3 = slots_q[47:32];
    assign mult_out_4 = slots_q[63:48];
    assign mult_out_5 = slots_q[79:64];
    assign mult_out_6 = slots_q[95:80];
    assign mult_out_7 = slots_q[111:96];
    assign mult_out_8 = slots_q[127:112];

endmodule

`default_nettype wire

// File: tb/tb_pp_issue_8.sv
// ============================================================================
// Module      : tb_pp_issue_8
// Description : Scoreboard bench for pp_issue_8 with a byte-product reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pp_issue_8;

    localparam int DRAIN = 4;
`ifdef MULT_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    typedef struct {
        logic [127:0] slots;
        logic         last;
        logic [1:0]   sew;
        int           cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [1:0]  in_sew = '0;
    logic        in_ready, start, pp_last, busy, err_sew;
    logic [1:0]  sew;
    logic [15:0] mo1, mo2, mo3, mo4, mo5, mo6, mo7, mo8;
    logic [127:0] slots_act;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_cyc = 0;
    bit drain_pend = 1'b0;
    bit checking = 1'b0;
    beat_t exp_q[$];
    int    err_q[$];

    pp_issue_8 #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sew(in_sew), .start(start), .sew(sew),
        .pp_last(pp_last), .mult_out_1(mo1), .mult_out_2(mo2), .mult_out_3(mo3),
        .mult_out_4(mo4), .mult_out_5(mo5), .mult_out_6(mo6), .mult_out_7(mo7),
        .mult_out_8(mo8), .busy(busy), .err_sew(err_sew)
    );

    assign slots_act = {mo8, mo7, mo6, mo5, mo4, mo3, mo2, mo1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: slot s of beat m as a byte product A[i]*B[j] chosen by lane geometry.
    function automatic logic [127:0] model(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] s, input int m);
        logic [127:0] r;
        int i, j;
        logic [15:0] ai, bj;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            i = -1; j = -1;
            if (s == 2'b00 && k < 4) begin i = k; j = k; end
            if (s == 2'b01) begin i = 2*(k/4) + (k%4)%2; j = 2*(k/4) + (k%4)/2; end
            if (s == 2'b10) begin i = k % 4; j = 2*m + k/4; end
            if (i >= 0) begin
                ai = 16'((a >> (8*i)) & 32'hFF);
                bj = 16'((b >> (8*j)) & 32'hFF);
                r[16*k +: 16] = ai * bj;
            end
        end
        return r;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] s, output int acc);
        int n;
        int nb;
        beat_t e;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_sew = s;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (!in_ready) begin
            chk("accept_timeout", 128'(in_ready), 128'(1));
            in_valid = 1'b0;
            return;
        end
        if (s == 2'b11) begin
            err_q.push_back(cyc + 1);
        end else begin
            nb = (s == 2'b10) ? 2 : 1;
            for (int m = 0; m < nb; m++) begin
                e.slots = model(a, b, s, m);
                e.last  = (m == nb - 1);
                e.sew   = s;
                e.cyc   = cyc + 1 + PIPE + m;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; in_sew = 2'($urandom);
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (checking && !reset) begin
            if (start) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 128'(start), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_slots", slots_act, e.slots);
                    chk("beat_last", 128'(pp_last), 128'(e.last));
                    chk("beat_sew", 128'(sew), 128'(e.sew));
                    chk("beat_cycle", 128'(cyc), 128'(e.cyc));
                end
                if (pp_last) begin
                    last_cyc   = cyc;
                    drain_pend = 1'b1;
                end
            end else begin
                chk("idle_outputs", {slots_act, 7'd0, pp_last}, 136'd0);
                if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    chk("missed_beat", 128'(0), 128'(1));
                end
            end
            if (err_sew) begin
                if (err_q.size() == 0) chk("unexpected_err", 128'(1), 128'(0));
                else chk("err_cycle", 128'(cyc), 128'(err_q.pop_front()));
            end else if (err_q.size() > 0 && err_q[0] < cyc) begin
                void'(err_q.pop_front());
                chk("missed_err", 128'(0), 128'(1));
            end
            if (drain_pend && in_ready) begin
                chk("drain_len", 128'(cyc - last_cyc), 128'(DRAIN + 1));
                drain_pend = 1'b0;
            end
            chk("busy_vs_ready", 128'(busy), 128'(!in_ready));
        end
    end

    initial begin
        int acc, acc2;
        logic [1:0] s;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_ready", 128'(in_ready), 128'(1));
        chk("reset_outs", {slots_act, 2'b0, sew, start, pp_last, busy, err_sew}, '0);
        checking = 1'b1;

        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, acc);
        issue(32'h04030201, 32'h08070605, 2'b00, acc);
        issue(32'h04030201, 32'h08070605, 2'b01, acc);

        // Back-to-back: second request waits with in_valid held high.
        issue(32'h89ABCDEF, 32'h01234567, 2'b10, acc);
        issue(32'hDEADBEEF, 32'hCAFEF00D, 2'b01, acc2);
        @(negedge clk);
        chk("b2b_accept_gap", 128'(acc2 - last_cyc), 128'(DRAIN + 1));

        issue(32'h12345678, 32'h9ABCDEF0, 2'b11, acc);
        @(negedge clk);
        chk("err_ready_next", 128'(in_ready), 128'(1));

        for (int t = 0; t < 40; t++) begin
            s = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue($urandom, $urandom, s, acc);
        end
        repeat (DRAIN + 6) @(negedge clk);

        // Reset during beat0 of a 32-bit request abandons beat1.
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, acc);
        repeat (PIPE) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        drain_pend = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mid_start", 128'(start), 128'(0));
        chk("rst_mid_slots", slots_act, 128'(0));
        chk("rst_mid_ready", 128'(in_ready), 128'(1));
        repeat (3) @(negedge clk);

        issue(32'h00FF00FF, 32'hFF00FF00, 2'b00, acc);
        repeat (DRAIN + 6) @(negedge clk);
        chk("queue_empty", 128'(exp_q.size() + err_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
